// File: rtl/irq_source_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : irq_source_ctrl_if
//  Brief    : Signal bundle between peripherals/CPU and the interrupt source
//             controller. "master" is the controller side, "slave" is the
//             CPU/peripheral side driving requests, masks and handshakes.
//  Revision : 1.0  initial release
// ============================================================================
interface irq_source_ctrl_if #(
  parameter int NUM_SRC = 8
);
  logic [NUM_SRC-1:0] irq_req;
  logic [NUM_SRC-1:0] irq_mask;
  logic               int_ack;
  logic               eret_n;
  logic               interrupt_signal_n;
  logic [3:0]         interrupt_index;
  logic               in_service;
  logic [NUM_SRC-1:0] pending;

  modport master (
    input  irq_req,
    input  irq_mask,
    input  int_ack,
    input  eret_n,
    output interrupt_signal_n,
    output interrupt_index,
    output in_service,
    output pending
  );

  modport slave (
    output irq_req,
    output irq_mask,
    output int_ack,
    output eret_n,
    input  interrupt_signal_n,
    input  interrupt_index,
    input  in_service,
    input  pending
  );
endinterface
`default_nettype wire

// File: rtl/irq_source_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : irq_source_ctrl
//  Brief    : Requesting end of the CPU interrupt interface. Latches rising
//             edges of peripheral requests as pending, picks the lowest-index
//             unmasked pending source, presents it on an active-low line with
//             a 4-bit vector index and tracks ack / eret so that only one
//             interrupt is ever outstanding. A request not acked within
//             TIMEOUT cycles is withdrawn and re-arbitrated.
//  Revision : 1.0  initial release
// ============================================================================
module irq_source_ctrl #(
  parameter int NUM_SRC = 8,   // 1..16
  parameter int TIMEOUT = 64   // 2..1023
) (
  input  logic              clk,
  input  logic              rst,
  irq_source_ctrl_if.master irq_if
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2,
    ST_GAP     = 2'd3
  } state_t;

  // Last count value of a presented request before it is withdrawn.
  localparam logic [9:0] c_TMO_LAST = 10'(TIMEOUT - 1);

  state_t             state_q;
  logic [NUM_SRC-1:0] prev_q;
  logic [NUM_SRC-1:0] pending_q;
  logic [NUM_SRC-1:0] pending_d;
  logic               sig_n_q;
  logic [3:0]         index_q;
  logic               in_service_q;
  logic [9:0]         cnt_q;

  logic [NUM_SRC-1:0] w_set_vec;
  logic [NUM_SRC-1:0] w_clr_vec;
  logic [NUM_SRC-1:0] w_sel_vec;
  logic [NUM_SRC-1:0] w_eligible;
  logic [3:0]         w_winner;
  logic               w_ack_take;
  logic               w_sel_masked;

  // Edge detect and pending next-state; a new edge beats a same-cycle clear.
  always_comb begin
    w_set_vec = irq_if.irq_req & ~prev_q;
    w_sel_vec = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (index_q == 4'(i)) begin
        w_sel_vec[i] = 1'b1;
      end
    end
    w_ack_take   = (state_q == ST_REQ) && irq_if.int_ack;
    w_clr_vec    = w_ack_take ? w_sel_vec : '0;
    w_sel_masked = |(w_sel_vec & irq_if.irq_mask);
    pending_d    = (pending_q & ~w_clr_vec) | w_set_vec;
  end

  // Fixed-priority arbiter: lowest eligible index wins.
  always_comb begin
    w_eligible = pending_q & ~irq_if.irq_mask;
    w_winner   = 4'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_eligible[i]) begin
        w_winner = 4'(i);
      end
    end
  end

  // Request history and pending bits. The history keeps following irq_req
  // during reset so a level held high across reset is not taken as an edge.
  always_ff @(posedge clk) begin
    prev_q <= irq_if.irq_req;
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Handshake state machine with registered line, index and in-service flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sig_n_q      <= 1'b1;
      index_q      <= 4'd0;
      in_service_q <= 1'b0;
      cnt_q        <= 10'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|w_eligible) begin
            state_q <= ST_REQ;
            sig_n_q <= 1'b0;
            index_q <= w_winner;
            cnt_q   <= 10'd0;
          end
        end
        ST_REQ: begin
          // Ack takes priority over a mask or timeout in the same cycle.
          if (irq_if.int_ack) begin
            state_q      <= ST_SERVICE;
            sig_n_q      <= 1'b1;
            in_service_q <= 1'b1;
          end else if (w_sel_masked || (cnt_q == c_TMO_LAST)) begin
            state_q <= ST_IDLE;
            sig_n_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 10'd1;
          end
        end
        ST_SERVICE: begin
          if (!irq_if.eret_n) begin
            in_service_q <= 1'b0;
            state_q      <= ST_GAP;
          end
        end
        ST_GAP: begin
          // Guarantees the line stays high before the next arbitration.
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign irq_if.interrupt_signal_n = sig_n_q;
  assign irq_if.interrupt_index    = index_q;
  assign irq_if.in_service         = in_service_q;
  assign irq_if.pending            = pending_q;

endmodule
`default_nettype wire
